// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, keeps one memory read in flight and queues words with their PCs.
// Optional macro HALT_FETCH_EN: stop fetching after an HLT (opcode 4'hF) word is queued; adds fetch_halted.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [15:0] inst_out,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_npc
`ifdef HALT_FETCH_EN
    ,
    output logic        fetch_halted
`endif
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t        state;
    logic [15:0]   fetch_pc;
    logic [15:0]   pc_hold;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;
    logic [15:0]   q_data [DEPTH];
    logic [15:0]   q_pc   [DEPTH];
    logic          push, pop, room, halt_blk;

    // Room is judged on next-cycle occupancy so a newly issued request always has a reserved slot.
    always_comb begin
        push      = (state == REQ) && imem_ack && !redirect;
        pop       = inst_valid && !stall && !redirect;
        count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
        room      = count_nxt < DEPTH_C;
    end

`ifdef HALT_FETCH_EN
    logic halted;
    assign halt_blk     = halted || (push && imem_rdata[15:12] == 4'hF);
    assign fetch_halted = halted;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            halted <= 1'b0;
        else if (redirect)
            halted <= 1'b0;
        else if (push && imem_rdata[15:12] == 4'hF)
            halted <= 1'b1;
    end
`else
    assign halt_blk = 1'b0;
`endif

    assign imem_addr = fetch_pc;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (count < DEPTH_C && !halt_blk) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        imem_req <= 1'b0;
                        state    <= imem_ack ? IDLE : DRAIN;
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + 16'd1;
                        if (!room || halt_blk) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The owed response belongs to the abandoned stream and is dropped.
                    if (redirect)
                        fetch_pc <= redirect_pc;
                    if (imem_ack) begin
                        if (!redirect && room && !halt_blk) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pc_hold <= 16'h0000;
        end else begin
            if (inst_valid)
                pc_hold <= q_pc[rd_ptr];
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            q_data[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // With the queue empty the PC outputs keep showing the last delivered instruction.
    always_comb begin
        inst_valid = (count != '0);
        inst_out   = inst_valid ? q_data[rd_ptr] : 16'h0000;
        inst_pc    = inst_valid ? q_pc[rd_ptr]   : pc_hold;
        inst_npc   = inst_pc + 16'd1;
    end

endmodule
